// File: rtl/pulse_analyzer.sv
// Pulse analyzer: synchronizes a two-bit probe bus and measures high time and rise-to-rise
// period of one selected channel per arm request. Optional macro PULSE_ANALYZER_GLITCH_FILTER_EN.
module pulse_analyzer #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [1:0]       probe_i,
   input  logic             ch_sel_i,
   input  logic             arm_i,
   output logic             busy_o,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [CNT_W-1:0] res_high_o,
   output logic [CNT_W-1:0] res_period_o,
   output logic             res_ovf_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [2:0] {
      StIdle,
      StWaitRise,
      StHigh,
      StLow,
      StDone
   } state_e;

   state_e                      state_q;
   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0]                  samp;
   logic [1:0]                  edge_q;
   logic                        ch_q;
   logic [CNT_W-1:0]            hi_q;
   logic [CNT_W-1:0]            per_q;
   logic [CNT_W-1:0]            hi_inc;
   logic [CNT_W-1:0]            per_inc;
   logic                        busy_q;
   logic                        valid_q;
   logic [CNT_W-1:0]            res_high_q;
   logic [CNT_W-1:0]            res_period_q;
   logic                        ovf_q;
   logic                        s_cur;
   logic                        s_prev;
   logic                        rise;
   logic                        fall;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], probe_i};
      end
   end

`ifdef PULSE_ANALYZER_GLITCH_FILTER_EN
   logic [1:0] hist1_q;
   logic [1:0] hist2_q;
   logic [1:0] filt_q;

   // Bitwise 2-of-3 majority over the last three synchronized samples.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         hist1_q <= '0;
         hist2_q <= '0;
         filt_q  <= '0;
      end else begin
         hist1_q <= sync_q[SYNC_STAGES-1];
         hist2_q <= hist1_q;
         filt_q  <= (sync_q[SYNC_STAGES-1] & hist1_q) |
                    (sync_q[SYNC_STAGES-1] & hist2_q) |
                    (hist1_q & hist2_q);
      end
   end

   assign samp = filt_q;
`else
   assign samp = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         edge_q <= '0;
      end else begin
         edge_q <= samp;
      end
   end

   assign s_cur   = samp[ch_q];
   assign s_prev  = edge_q[ch_q];
   assign rise    = s_cur & ~s_prev;
   assign fall    = ~s_cur & s_prev;
   assign hi_inc  = hi_q + 1'b1;
   assign per_inc = per_q + 1'b1;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q      <= StIdle;
         ch_q         <= 1'b0;
         hi_q         <= '0;
         per_q        <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         res_high_q   <= '0;
         res_period_q <= '0;
         ovf_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arm_i) begin
                  ch_q    <= ch_sel_i;
                  hi_q    <= '0;
                  per_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StWaitRise;
               end
            end
            StWaitRise: begin
               if (rise) begin
                  hi_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
                  per_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                  state_q <= StHigh;
               end else if (per_inc == CntMax) begin
                  per_q        <= CntMax;
                  res_high_q   <= '0;
                  res_period_q <= CntMax;
                  ovf_q        <= 1'b1;
                  valid_q      <= 1'b1;
                  state_q      <= StDone;
               end else begin
                  per_q <= per_inc;
               end
            end
            StHigh: begin
               // hi_q never exceeds per_q, but both are checked so either can end the run.
               if ((per_inc == CntMax) || (!fall && (hi_inc == CntMax))) begin
                  per_q        <= per_inc;
                  hi_q         <= fall ? hi_q : hi_inc;
                  res_period_q <= per_inc;
                  res_high_q   <= fall ? hi_q : hi_inc;
                  ovf_q        <= 1'b1;
                  valid_q      <= 1'b1;
                  state_q      <= StDone;
               end else begin
                  per_q <= per_inc;
                  if (fall) begin
                     state_q <= StLow;
                  end else begin
                     hi_q <= hi_inc;
                  end
               end
            end
            StLow: begin
               if (rise) begin
                  res_period_q <= per_q;
                  res_high_q   <= hi_q;
                  ovf_q        <= 1'b0;
                  valid_q      <= 1'b1;
                  state_q      <= StDone;
               end else if (per_inc == CntMax) begin
                  per_q        <= CntMax;
                  res_period_q <= CntMax;
                  res_high_q   <= hi_q;
                  ovf_q        <= 1'b1;
                  valid_q      <= 1'b1;
                  state_q      <= StDone;
               end else begin
                  per_q <= per_inc;
               end
            end
            StDone: begin
               // arm_i is deliberately not looked at here, even on the handshake cycle.
               if (res_ready_i) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign res_valid_o  = valid_q;
   assign res_high_o   = res_high_q;
   assign res_period_o = res_period_q;
   assign res_ovf_o    = ovf_q;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Self-checking bench for pulse_analyzer: table of waveforms with a result scoreboard plus
// hand-written sequences for result hold, saturation, timeout and mid-measurement reset.
module tb_pulse_analyzer;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned SMALL_W = 8;
   localparam int          MAX16   = 65535;
   localparam int          MAX8    = 255;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [1:0]         probe = 2'b11;
   logic               ch_sel = 1'b0;
   logic               arm = 1'b0;
   logic               busy;
   logic               res_valid;
   logic               res_ready = 1'b1;
   logic [CNT_W-1:0]   res_high;
   logic [CNT_W-1:0]   res_period;
   logic               res_ovf;

   logic [1:0]         probe_s = 2'b11;
   logic               ch_s = 1'b0;
   logic               arm_s = 1'b0;
   logic               busy_s;
   logic               valid_s;
   logic [SMALL_W-1:0] high_s;
   logic [SMALL_W-1:0] period_s;
   logic               ovf_s;

   always #5 clk = ~clk;

   pulse_analyzer #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .probe_i     (probe),
      .ch_sel_i    (ch_sel),
      .arm_i       (arm),
      .busy_o      (busy),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_high_o  (res_high),
      .res_period_o(res_period),
      .res_ovf_o   (res_ovf)
   );

   // Narrow instance so counter saturation is reachable in a few hundred cycles.
   pulse_analyzer #(.CNT_W(SMALL_W), .SYNC_STAGES(2)) dut_s (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .probe_i     (probe_s),
      .ch_sel_i    (ch_s),
      .arm_i       (arm_s),
      .busy_o      (busy_s),
      .res_valid_o (valid_s),
      .res_ready_i (1'b1),
      .res_high_o  (high_s),
      .res_period_o(period_s),
      .res_ovf_o   (ovf_s)
   );

   typedef struct {
      logic ch;
      int   hi;
      int   lo;
      int   gl;
      int   eh;
      int   ep;
      logic eo;
   } vec_t;

   typedef struct {
      int   h;
      int   p;
      logic o;
   } exp_t;

   vec_t tbl[7];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Arm, drive the selected channel with the row's waveform (the other channel inverted),
   // then pop the expected result when res_valid shows up.
   task automatic run_meas(input int idx);
      vec_t v;
      exp_t e;
      int   budget;
      logic got;
      logic lvl;
      v = tbl[idx];
      sb_q.push_back('{h: v.eh, p: v.ep, o: v.eo});
      budget = (v.hi == 0) ? MAX16 + 80 : 2 * (v.hi + v.lo) + 40;
      ch_sel = v.ch;
      arm    = 1'b1;
      @(negedge clk);
      arm    = 1'b0;
      ch_sel = ~v.ch;
      check($sformatf("busy_after_arm[%0d]", idx), int'(busy), 1);
      got = 1'b0;
      for (int cyc = 0; cyc < budget && !got; cyc++) begin
         lvl = (v.hi > 0) && ((cyc % (v.hi + v.lo)) < v.hi);
         if (cyc == v.gl) lvl = ~lvl;
         probe = v.ch ? {lvl, ~lvl} : {~lvl, lvl};
         @(negedge clk);
         if (res_valid) got = 1'b1;
      end
      probe = 2'b00;
      check($sformatf("valid[%0d]", idx), int'(got), 1);
      e = sb_q.pop_front();
      check($sformatf("high[%0d]", idx), int'(res_high), e.h);
      check($sformatf("period[%0d]", idx), int'(res_period), e.p);
      check($sformatf("ovf[%0d]", idx), int'(res_ovf), int'(e.o));
      if (res_ready) repeat (10) @(negedge clk);
   endtask

   initial begin
      logic got;
      logic saw;

      tbl[0] = '{ch: 1'b0, hi: 30, lo: 70, gl: -1, eh: 30, ep: 100, eo: 1'b0};
      tbl[1] = '{ch: 1'b1, hi: 30, lo: 70, gl: -1, eh: 30, ep: 100, eo: 1'b0};
      tbl[2] = '{ch: 1'b0, hi: 5,  lo: 3,  gl: -1, eh: 5,  ep: 8,   eo: 1'b0};
      tbl[3] = '{ch: 1'b0, hi: 2,  lo: 2,  gl: -1, eh: 2,  ep: 4,   eo: 1'b0};
`ifdef PULSE_ANALYZER_GLITCH_FILTER_EN
      tbl[4] = '{ch: 1'b1, hi: 2,  lo: 20, gl: -1, eh: 2,  ep: 22,  eo: 1'b0};
      tbl[5] = '{ch: 1'b0, hi: 30, lo: 70, gl: 60, eh: 30, ep: 100, eo: 1'b0};
`else
      tbl[4] = '{ch: 1'b1, hi: 1,  lo: 20, gl: -1, eh: 1,  ep: 21,  eo: 1'b0};
      tbl[5] = '{ch: 1'b0, hi: 30, lo: 70, gl: 60, eh: 30, ep: 60,  eo: 1'b0};
`endif
      tbl[6] = '{ch: 1'b1, hi: 0,  lo: 1,  gl: -1, eh: 0,  ep: MAX16, eo: 1'b1};

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(res_valid), 0);
      check("rst_high", int'(res_high), 0);
      check("rst_period", int'(res_period), 0);
      check("rst_ovf", int'(res_ovf), 0);
      check("rst_small_valid", int'(valid_s), 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_valid", int'(res_valid), 0);
      probe   = 2'b00;
      probe_s = 2'b00;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 6; i++) run_meas(i);

      // Result hold while the consumer stalls, with arm pulses that must be ignored.
      res_ready = 1'b0;
      run_meas(0);
      for (int k = 0; k < 20; k++) begin
         arm = (k % 3 == 0);
         @(negedge clk);
         check("hold_valid", int'(res_valid), 1);
         check("hold_busy", int'(busy), 1);
         check("hold_high", int'(res_high), 30);
         check("hold_period", int'(res_period), 100);
      end
      arm       = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      check("rel_valid", int'(res_valid), 0);
      check("rel_busy", int'(busy), 0);
      check("kept_high", int'(res_high), 30);
      @(negedge clk);
      check("rel_busy2", int'(busy), 0);
      repeat (10) @(negedge clk);

      // Saturation in HIGH on the narrow instance.
      ch_s  = 1'b0;
      arm_s = 1'b1;
      @(negedge clk);
      arm_s   = 1'b0;
      probe_s = 2'b01;
      got     = 1'b0;
      for (int c = 0; c < 600 && !got; c++) begin
         @(negedge clk);
         if (valid_s) got = 1'b1;
      end
      check("sat_valid", int'(got), 1);
      check("sat_high", int'(high_s), MAX8);
      check("sat_period", int'(period_s), MAX8);
      check("sat_ovf", int'(ovf_s), 1);
      probe_s = 2'b00;
      repeat (10) @(negedge clk);

      // No rise on the selected channel while the other one toggles once.
      ch_s  = 1'b1;
      arm_s = 1'b1;
      @(negedge clk);
      arm_s   = 1'b0;
      probe_s = 2'b01;
      got     = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clk);
         if (valid_s) got = 1'b1;
      end
      check("to8_valid", int'(got), 1);
      check("to8_high", int'(high_s), 0);
      check("to8_period", int'(period_s), MAX8);
      check("to8_ovf", int'(ovf_s), 1);
      probe_s = 2'b00;
      repeat (10) @(negedge clk);

      // Reset in the middle of HIGH aborts without a result.
      ch_sel = 1'b0;
      arm    = 1'b1;
      @(negedge clk);
      arm   = 1'b0;
      probe = 2'b01;
      repeat (12) @(negedge clk);
      check("mid_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_valid", int'(res_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      saw   = 1'b0;
      for (int c = 0; c < 250; c++) begin
         probe = ((c % 100) < 30) ? 2'b01 : 2'b00;
         @(negedge clk);
         if (res_valid || busy) saw = 1'b1;
      end
      check("abort_no_result", int'(saw), 0);
      probe = 2'b00;
      repeat (10) @(negedge clk);

      run_meas(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
